fifo: RTL and testbench

FIFO -- requirements
Module: fifo

---
 rtl/fifo.sv | 68 ++++++
 tb/tb_fifo.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// Synchronous first-word fall-through FIFO with registered full/empty flags.
// DEPTH may be any integer >= 2; pointers wrap explicitly at DEPTH-1.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] write_data,
  output logic             full,
  input  logic             read_enable,
  output logic [WIDTH-1:0] read_data,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             wr_ok;
  logic             rd_ok;

  // Handshake: a side transfers on a rising edge only when its enable is high
  // and the FIFO can take it (write: !full, read: !empty); blocked requests are
  // dropped silently, so enables never need to be held.
  assign wr_ok = write_enable && !full;
  assign rd_ok = read_enable && !empty;

  assign read_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= write_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo: a queue model tracks accepted
// transfers and predicts head data and flags every cycle.
module tb_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clock;
  logic             resetn;
  logic             write_enable;
  logic [WIDTH-1:0] write_data;
  logic             full;
  logic             read_enable;
  logic [WIDTH-1:0] read_data;
  logic             empty;

  logic [WIDTH-1:0] exp_q[$];
  int n_checks;
  int n_errors;

  fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .write_enable (write_enable),
    .write_data   (write_data),
    .full         (full),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .empty        (empty)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check head before the edge, then update
  // the model and check flags just after the edge.
  task automatic cycle(input logic we, input logic [WIDTH-1:0] wd, input logic re,
                       input string tag);
    bit wr_ok;
    bit rd_ok;
    @(negedge clock);
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    wr_ok = we && (exp_q.size() < DEPTH);
    rd_ok = re && (exp_q.size() > 0);
    #1;
    if (rd_ok) check({tag, "_rdata"}, 32'(read_data), 32'(exp_q[0]));
    @(posedge clock);
    #1;
    if (rd_ok) void'(exp_q.pop_front());
    if (wr_ok) exp_q.push_back(wd);
    check({tag, "_full"},  32'(full),  32'(exp_q.size() == DEPTH));
    check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  initial begin
    int writes;
    int cyc;
    logic [WIDTH-1:0] d;
    n_checks = 0;
    n_errors = 0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    write_data   = '0;
    resetn       = 1'b0;
    #12;
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full",  32'(full),  32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // fill with random bytes, then a blocked write of 0xAA
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'($urandom_range(0, 255)), 1'b0, "fill");
    check("fill_full_flag", 32'(full), 32'd1);
    cycle(1'b1, 8'hAA, 1'b0, "wr_when_full");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, "drain");
    check("drain_empty_flag", 32'(empty), 32'd1);

    // read from empty is ignored
    cycle(1'b0, 8'h00, 1'b1, "rd_when_empty");

    // streaming: write 0..99, read from second cycle on
    cycle(1'b1, 8'd0, 1'b0, "stream0");
    for (int i = 1; i < 100; i++) begin
      cycle(1'b1, WIDTH'(i), 1'b1, "stream");
      check("stream_prev", 32'(exp_q[0]), 32'(i));
    end
    cycle(1'b0, 8'h00, 1'b1, "stream_last");
    check("stream_end_empty", 32'(empty), 32'd1);

    // write+read while empty: only the write lands, head shows it next cycle
    cycle(1'b1, 8'h3C, 1'b1, "wr_rd_empty");
    #1;
    check("wr_rd_empty_head", 32'(read_data), 32'h3C);
    // fill, then write+read while full: only the read lands
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, WIDTH'(8'h40 + i), 1'b0, "refill");
    cycle(1'b1, 8'hEE, 1'b1, "wr_rd_full");
    check("wr_rd_full_head", 32'(read_data), 32'h40);
    while (exp_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, "drain2");

    // random 50% traffic until 100 writes accepted
    writes = 0;
    cyc = 0;
    while (writes < 100 && cyc < 5000) begin
      bit we;
      bit re;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      if (we && exp_q.size() < DEPTH) writes++;
      cycle(we, WIDTH'($urandom_range(0, 255)), re, "rand");
      cyc++;
    end
    check("rand_writes_done", 32'(writes), 32'd100);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      cycle(1'b0, 8'h00, 1'b1, "rand_drain");
      cyc++;
    end
    check("rand_end_empty", 32'(empty), 32'd1);

    // asynchronous reset with two words stored
    cycle(1'b1, 8'h11, 1'b0, "pre_rst");
    cycle(1'b1, 8'h22, 1'b0, "pre_rst");
    @(negedge clock);
    #1;
    resetn = 1'b0;
    #1;
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_full",  32'(full),  32'd0);
    exp_q.delete();
    @(negedge clock);
    resetn = 1'b1;
    d = 8'h5C;
    cycle(1'b1, d, 1'b0, "post_rst_wr");
    check("post_rst_head", 32'(read_data), 32'h5C);
    cycle(1'b0, 8'h00, 1'b1, "post_rst_rd");
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
